// File: rtl/credit_fifo_sender_pkg.sv
// Shared definitions for the credit-flow link: sender state encoding,
// reused by the receive-side credit returner.
package credit_fifo_sender_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sender_state_e;

endpackage : credit_fifo_sender_pkg

// File: rtl/credit_fifo_sender_credit_counter.sv
// Up/down saturating credit counter. Resets to MAX, saturates at MAX on an
// unmatched increment and raises a sticky overflow flag when that happens.
// An unmatched decrement at zero holds the count at zero.
module credit_fifo_sender_credit_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_overflow
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;
    logic             r_overflow;
    logic [WIDTH:0]   w_sum;
    logic             w_under;
    logic             w_over;

    // Next count at one extra bit so a step past MAX is visible before truncation.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_sum   = '0;
        w_under = 1'b0;
        w_over  = 1'b0;
        w_sum   = {1'b0, r_count} + {{WIDTH{1'b0}}, i_inc} - {{WIDTH{1'b0}}, i_dec};
        w_under = i_dec && !i_inc && (r_count == '0);
        w_over  = !w_under && (w_sum > {1'b0, MAX_VAL});
    end

    // Count register with saturation at both ends and a sticky overflow flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_count    <= MAX_VAL;
            r_overflow <= 1'b0;
        end else if (w_over) begin
            r_overflow <= 1'b1;
        end else if (!w_under) begin
            r_count <= w_sum[WIDTH-1:0];
        end
    end

    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule : credit_fifo_sender_credit_counter

// File: rtl/credit_fifo_sender.sv
// Transmit end of a credit-flow link. Accepts producer words over
// valid/ready, registers them onto the link one cycle later, and spends one
// credit per word so the remote FIFO (RX_DEPTH entries) never overflows.
// A level drain request quiesces the link until every credit is back.
module credit_fifo_sender
    import credit_fifo_sender_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int RX_DEPTH   = 8,
    localparam int CRED_WIDTH = $clog2(RX_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  credit_ret,
    input  logic                  drain_req,
    output logic                  drain_done,
    output logic [CRED_WIDTH-1:0] credits,
    output logic                  err_overflow
);

    localparam logic [CRED_WIDTH-1:0] FULL_CREDITS = CRED_WIDTH'(RX_DEPTH);

    sender_state_e         r_state;
    logic                  r_drain_done;
    logic                  r_tx_valid;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic [CRED_WIDTH-1:0] w_credits;
    logic                  w_overflow;
    logic                  w_ready;
    logic                  w_acc;

    // Ready comes only from registered state, never from credit_ret.
    assign w_ready = (r_state == RUN) && (w_credits != '0);
    assign w_acc   = in_valid && w_ready;

    credit_fifo_sender_credit_counter #(
        .WIDTH (CRED_WIDTH),
        .MAX   (RX_DEPTH)
    ) u_credit_counter (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (credit_ret),
        .i_dec      (w_acc),
        .o_count    (w_credits),
        .o_overflow (w_overflow)
    );

    // Drain handshake FSM; drain_done is registered and tracks the DONE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_drain_done <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (drain_req) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!drain_req) begin
                        r_state <= RUN;
                    end else if ((w_credits == FULL_CREDITS) && !r_tx_valid) begin
                        r_state      <= DONE;
                        r_drain_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (!drain_req) begin
                        r_state      <= RUN;
                        r_drain_done <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= RUN;
                    r_drain_done <= 1'b0;
                end
            endcase
        end
    end

    // Link register: one-cycle valid pulse per accepted word, payload held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_valid <= w_acc;
            if (w_acc) begin
                r_tx_data <= in_data;
            end
        end
    end

    assign in_ready     = w_ready;
    assign tx_valid     = r_tx_valid;
    assign tx_data      = r_tx_data;
    assign drain_done   = r_drain_done;
    assign credits      = w_credits;
    assign err_overflow = w_overflow;

endmodule : credit_fifo_sender

// File: tb/tb_credit_fifo_sender.sv
// Randomised scoreboard bench for credit_fifo_sender (RX_DEPTH=4, DATA_WIDTH=32).
module tb_credit_fifo_sender;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_DONE  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          credit_ret;
    logic          drain_req;
    logic          drain_done;
    logic [CW-1:0] credits;
    logic          err_overflow;

    always #5 clk = ~clk;

    credit_fifo_sender #(
        .DATA_WIDTH (DW),
        .RX_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .credit_ret   (credit_ret),
        .drain_req    (drain_req),
        .drain_done   (drain_done),
        .credits      (credits),
        .err_overflow (err_overflow)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: words in flight, free remote slots, drain mode.
    logic [DW-1:0] exp_q[$];
    int m_credits = DEPTH;
    int m_mode    = M_RUN;
    bit m_tx_valid = 1'b0;
    bit m_err      = 1'b0;
    bit mon_en     = 1'b0;

    function automatic bit m_ready();
        return (m_mode == M_RUN) && (m_credits > 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: predict acceptance, advance the model at the edge.
    task automatic step();
        bit acc;
        acc = !rst && in_valid && m_ready();
        if (acc) exp_q.push_back(in_data);
        @(posedge clk);
        if (rst) begin
            m_credits  = DEPTH;
            m_mode     = M_RUN;
            m_tx_valid = 1'b0;
            m_err      = 1'b0;
            exp_q.delete();
        end else begin
            case (m_mode)
                M_RUN:   if (drain_req) m_mode = M_DRAIN;
                M_DRAIN: begin
                    if (!drain_req) m_mode = M_RUN;
                    else if (m_credits == DEPTH && !m_tx_valid) m_mode = M_DONE;
                end
                default: if (!drain_req) m_mode = M_RUN;
            endcase
            if (credit_ret && !acc && m_credits == DEPTH) m_err = 1'b1;
            else m_credits = m_credits + int'(credit_ret) - int'(acc);
            m_tx_valid = acc;
        end
        #1;
    endtask

    // Monitor: compares link output against the scoreboard and status against the model.
    always @(negedge clk) begin : monitor
        logic [DW-1:0] e;
        if (mon_en) begin
            check("tx_valid", tx_valid, m_tx_valid);
            if (tx_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tx_data_unexpected: got 0x%0h with no word expected at %0t", tx_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", tx_data, e);
                end
            end
            check("credits", credits, m_credits);
            check("in_ready", in_ready, m_ready());
            check("drain_done", drain_done, m_mode == M_DONE);
            check("err_overflow", err_overflow, m_err);
        end
    end

    initial begin
        int idx;
        bit pre;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; credit_ret = 1'b0; drain_req = 1'b0;
        step();
        step();
        mon_en = 1'b1;
        rst = 1'b0;
        check("reset_credits", credits, DEPTH);
        check("reset_in_ready", in_ready, 1);
        repeat (2) step();

        // Fill the remote FIFO with 0xA0..0xA3; 0xA4 must wait.
        idx = 0;
        in_valid = 1'b1;
        repeat (8) begin
            in_data = 32'hA0 + idx;
            pre = m_ready();
            step();
            if (pre) idx++;
        end
        check("credits_exhausted", credits, 0);
        check("a4_held", in_data, 32'hA4);

        // One credit back lets 0xA4 through.
        credit_ret = 1'b1;
        step();
        credit_ret = 1'b0;
        check("one_credit", credits, 1);
        repeat (3) begin
            in_data = 32'hA0 + idx;
            pre = m_ready();
            step();
            if (pre) idx++;
        end
        in_valid = 1'b0;
        check("a4_sent_credits", credits, 0);

        // Bring credits to 2, then accept and return every cycle.
        credit_ret = 1'b1;
        repeat (2) step();
        in_valid = 1'b1;
        repeat (10) begin
            in_data = $urandom;
            step();
        end
        in_valid = 1'b0; credit_ret = 1'b0;
        step();
        check("steady_credits", credits, 2);

        // Drain from credits=1.
        in_valid = 1'b1; in_data = $urandom;
        step();
        in_valid = 1'b0;
        drain_req = 1'b1;
        step();
        check("drain_blocks_ready", in_ready, 0);
        repeat (3) begin
            credit_ret = 1'b1; step();
            credit_ret = 1'b0; step();
        end
        check("drain_done_set", drain_done, 1);
        drain_req = 1'b0;
        step();
        check("drain_release_ready", in_ready, 1);
        step();

        // Overflow with a full count is sticky.
        credit_ret = 1'b1;
        step();
        credit_ret = 1'b0;
        repeat (3) step();
        check("err_sticky", err_overflow, 1);
        check("credits_saturated", credits, DEPTH);

        // Random traffic with drain requests.
        repeat (400) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = $urandom;
            credit_ret = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
            step();
        end

        // Reset in the middle of a send.
        drain_req = 1'b0; in_valid = 1'b0; credit_ret = 1'b1;
        repeat (5) step();
        credit_ret = 1'b0;
        in_valid = 1'b1; in_data = $urandom;
        step();
        rst = 1'b1; in_data = $urandom;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_credits", credits, DEPTH);
        check("rst_err", err_overflow, 0);
        repeat (3) step();

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_credit_fifo_sender

// File: doc/credit_fifo_sender.md
Name: credit_fifo_sender

Overview:
- Transmit end of a credit-flow link into a remote receive FIFO of RX_DEPTH entries. The remote FIFO has no backpressure wire; it returns one credit pulse per dequeued entry.
- Accepts words from a local producer over valid/ready, registers them onto the link, and keeps a credit counter so the remote FIFO never overflows.
- Used between a dispatch-side producer and a remote queue whose ready signal cannot reach the producer in the same cycle.
- Supports a drain handshake that quiesces the link until every credit has returned.

Parameters:
- DATA_WIDTH, 32, payload width.
- RX_DEPTH, 8, entries in the remote FIFO; also the initial credit count. Must be >= 1.
- CRED_WIDTH, $clog2(RX_DEPTH+1), localparam, credit counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  sender will accept the word this cycle.
- in_data  in  DATA_WIDTH  producer payload.
- tx_valid  out  1  link carries a word this cycle (registered).
- tx_data  out  DATA_WIDTH  link payload (registered).
- credit_ret  in  1  remote FIFO returns one credit this cycle.
- drain_req  in  1  level request to stop accepting and wait for all credits.
- drain_done  out  1  level: drain complete and link idle.
- credits  out  CRED_WIDTH  current credit count (debug).
- err_overflow  out  1  sticky: a credit was returned while the count was already RX_DEPTH.

Behaviour:
- Reset is synchronous, active-high, sampled at posedge clk. Reset values: credits=RX_DEPTH, tx_valid=0, tx_data=0, err_overflow=0, state=RUN, drain_done=0, in_ready=1 (RX_DEPTH>=1). Asserting reset mid-transfer discards any in-flight tx word, and credits return to RX_DEPTH on the next edge.
- Accept condition: acc = in_valid && in_ready.
- in_ready = (state==RUN) && (credits!=0). in_ready depends only on registered state; there is no combinational path from credit_ret to in_ready.
- Latency: a word accepted in cycle N appears as tx_valid=1 with tx_data=in_data in cycle N+1, held for exactly one cycle. tx_valid next = acc. tx_data loads only on acc and otherwise holds.
- Credit arithmetic: credits_next = credits - acc + credit_ret, computed at CRED_WIDTH+1 bits.
- Simultaneous acc and credit_ret leave the count unchanged.
- When credits==0, acc cannot occur; a credit_ret that cycle gives 1 next cycle.
- If credits==RX_DEPTH and credit_ret=1 and acc=0, the count saturates at RX_DEPTH and err_overflow sets. err_overflow clears only on rst.
- State machine:
  - RUN: normal operation. Goes to DRAIN when drain_req=1. The transition is sampled at posedge, so acceptance stops the cycle after drain_req is seen.
  - DRAIN: in_ready=0; credits are still collected. Goes to DONE when credits==RX_DEPTH && tx_valid==0. Goes back to RUN if drain_req drops first.
  - DONE: drain_done=1, in_ready=0. Goes to RUN when drain_req=0.
  - drain_done is registered: it is 1 exactly while state==DONE.
- A drain requested while the count is already full and the link is idle reaches DONE two cycles after drain_req rises (RUN to DRAIN, then DRAIN to DONE).

Decomposition:
- Shared package (misc pkg) holds a typedef enum logic [1:0] {RUN, DRAIN, DONE} for the sender state. The same enum is reused by a future receiver-side credit returner.
- One natural sub-module: credit_counter. It is an up/down saturating counter with inc, dec, reset value and overflow flag, and will be reused on the receive side.
- The FSM and the tx register stay in the top module.

Test Plan (RX_DEPTH=4, DATA_WIDTH=32):
- Reset then idle: credits=4, in_ready=1, tx_valid=0, drain_done=0, err_overflow=0.
- in_valid held with data 0xA0..0xA5 and no credit_ret:
  - four words accepted; tx_valid pulses with 0xA0..0xA3 one cycle after each accept.
  - credits reaches 0 and in_ready drops.
  - 0xA4 is held and not sent.
- From credits=0, pulse credit_ret once: credits=1, in_ready=1 the next cycle; 0xA4 is accepted and then credits=0.
- Simultaneous accept and credit_ret every cycle with credits=2: credits stays 2 and one word is sent per cycle for 10 cycles.
- Drain:
  - with credits=1, assert drain_req: in_ready=0 the next cycle.
  - after 3 credit_ret pulses, credits=4 and drain_done=1 one cycle later.
  - drop drain_req: state RUN and in_ready=1 the next cycle.
- Overflow and reset:
  - with credits=4, pulse credit_ret: credits stays 4 and err_overflow=1, which persists.
  - assert rst for 1 cycle during an active send: tx_valid=0, credits=4, err_overflow=0 after the edge.
